bit_alu_pe: RTL and testbench
=============================

# bit_alu_pe

Parametrised, pipelined bitwise-logic processing element: the next generation of the fixed 16-bit, 2-op-select combinational bit ALU PE. Operand width is a parameter, and a 3-bit opcode selects one of 8 logic ops. The block has two register stages with valid/ready flow control, registered zero, sign and parity flags, and an optional result-feedback (accumulate) operand. It sits inside the PE tile between the operand routing network and the output crossbar.

## Interface
- WIDTH, 16, operand and result width in bits; legal range ≥ 2.
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- clk_en  input  1  global stall; while low, all state holds, in_ready=0 and out_valid=0.
- inst  input  4  [2:0] opcode, [3] acc_sel; captured together with the operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  upstream operand/inst valid.
- in_ready  output  1  block can accept this cycle.
- O  output  WIDTH  registered result.
- flag_z  output  1  O == 0.
- flag_n  output  1  O[WIDTH-1].
- flag_p  output  1  XOR-reduction of O (odd parity).
- out_valid  output  1  O and flags valid.
- out_ready  input  1  downstream accepts.

## Operation
- Opcodes, with B' = (acc_sel ? acc_reg : b):
  - 0 OR a|B'
  - 1 AND a&B'
  - 2 XOR a^B'
  - 3 NAND ~(a&B')
  - 4 NOR ~(a|B')
  - 5 XNOR ~(a^B')
  - 6 ANDN a&~B'
  - 7 PASS a
- Stage S1 (input register): holds a, b, inst and s1_valid.
  - Loads on an input transfer (in_valid & in_ready & clk_en).
  - s1_valid clears when S1 advances without a new load.
- Stage S2 (output register): holds O, the flags and s2_valid.
  - Result and flags are computed combinationally from S1.
  - S2 loads when s1_valid & (!s2_valid | out_ready) & clk_en.
- Ready logic:
  - s2_accept = !s2_valid | out_ready.
  - in_ready = clk_en & (!s1_valid | s2_accept).
- Output transfer occurs on out_valid & out_ready. s2_valid clears on a transfer with no simultaneous S1 advance.
- Simultaneous output transfer, S1 advance and input load in one cycle is legal and sustains 1 op/cycle.
- acc_reg (WIDTH bits):
  - Loads the computed result on every S1→S2 advance, regardless of acc_sel.
  - A back-to-back op with acc_sel=1 therefore sees the immediately preceding result.
- Flags are computed from the WIDTH-bit result before registering, so they always correspond to the O currently presented.
- All logic is pure bitwise; there is no carry and no width growth.

## Timing
- Latency: an input accepted at edge k is presented at out_valid after edge k+1, i.e. 2 cycles after in_valid assertion with no stall.
- Throughput: 1 op/cycle while out_ready=1.
- Backpressure: with out_ready=0, one more op is absorbed into S1. in_ready then drops in the next cycle and both stages hold their values bit-stable.
- While out_valid=1 and out_ready=0, O and the flags must not change.
- Reset values: s1_valid=0, s2_valid=0, O=0, acc_reg=0, flag_z=1, flag_n=0, flag_p=0, out_valid=0. in_ready=1 after reset when clk_en=1.
- RESET asserted mid-operation discards both stages. No partial output appears after the reset edge.
- RESET takes priority over clk_en.
- clk_en low: S1, S2 and acc_reg hold. No transfers are counted in either direction, even if in_valid/out_ready are high.

## Configuration
- BIT_ALU_PE_ACC_EN defined:
  - acc_reg is implemented.
  - inst[3] selects acc_reg as operand B.
- BIT_ALU_PE_ACC_EN undefined:
  - acc_reg is absent.
  - inst[3] is ignored (B'=b always).
  - Flops and flag behaviour are otherwise identical.

## Test plan
- Reset, then each opcode with WIDTH=16, a=0x00F0, b=0x0F0F, out_ready=1 → O = 0x0FFF, 0x0000 (z=1), 0x0FFF, 0xFFFF (n=1, p=0), 0xF000, 0xF000, 0x00F0, 0x00F0. Each appears 2 cycles after in_valid.
- Streaming 8 ops back-to-back with out_ready=1 → in_ready stays 1 and 8 consecutive out_valid cycles occur in order.
- out_ready=0 for 5 cycles during a stream → in_ready falls after 2 accepts, O is stable, and no op is lost or duplicated when out_ready returns.
- With ACC_EN: OR a=0x0001 b=0; then OR acc_sel=1 with a=0x0002, 0x0004 → O = 0x0001, 0x0003, 0x0007. Without the macro, same stimulus → 0x0001, 0x0002, 0x0004.
- RESET pulsed with both stages full → out_valid=0 and O=0 on the next cycle, and nothing stale emerges afterward.
- clk_en=0 for 3 cycles mid-stream with in_valid=1 → in_ready=0, out_valid=0 and state frozen; the stream resumes unchanged.

Source files
------------

// File: rtl/bit_alu_pe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : bit_alu_pe
// Purpose  : Two-stage pipelined bitwise-logic processing element. Stage S1
//            registers operands and instruction; stage S2 registers the
//            result and its zero/sign/parity flags. Valid/ready handshakes
//            on both sides, plus a global stall (clk_en).
// Option   : BIT_ALU_PE_ACC_EN - adds acc_reg, which holds the last result
//            that entered S2. inst[3] (acc_sel) then selects acc_reg as
//            operand B. Without the macro, inst[3] is ignored.
// Ports    : CLK, RESET (sync, active high), clk_en (global stall)
//            inst[3:0] = {acc_sel, opcode[2:0]}, a, b, in_valid / in_ready
//            O, flag_z, flag_n, flag_p, out_valid / out_ready
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module bit_alu_pe #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             clk_en,
   input  logic [3:0]       inst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] O,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_p,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam logic [2:0] c_OP_OR   = 3'd0;
   localparam logic [2:0] c_OP_AND  = 3'd1;
   localparam logic [2:0] c_OP_XOR  = 3'd2;
   localparam logic [2:0] c_OP_NAND = 3'd3;
   localparam logic [2:0] c_OP_NOR  = 3'd4;
   localparam logic [2:0] c_OP_XNOR = 3'd5;
   localparam logic [2:0] c_OP_ANDN = 3'd6;
   localparam logic [2:0] c_OP_PASS = 3'd7;

   // Stage S1
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [3:0]       r_s1_inst;
   logic             r_s1_valid;

   // Stage S2
   logic [WIDTH-1:0] r_s2_o;
   logic             r_s2_z;
   logic             r_s2_n;
   logic             r_s2_p;
   logic             r_s2_valid;

   logic             w_s2_accept;
   logic             w_s1_adv;
   logic             w_in_load;
   logic             w_out_xfer;
   logic [WIDTH-1:0] w_op_b;
   logic [WIDTH-1:0] w_res;

   // Handshake terms. clk_en gates every transfer so a stall freezes all state.
   assign w_s2_accept = !r_s2_valid || out_ready;
   assign in_ready    = clk_en && (!r_s1_valid || w_s2_accept);
   assign w_in_load   = in_valid && in_ready;
   assign w_s1_adv    = r_s1_valid && w_s2_accept && clk_en;
   assign w_out_xfer  = r_s2_valid && out_ready && clk_en;

`ifdef BIT_ALU_PE_ACC_EN
   logic [WIDTH-1:0] r_acc;

   // acc_reg follows every S1->S2 advance, whether or not acc_sel was used,
   // so a back-to-back acc_sel op sees the result just ahead of it.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_acc <= '0;
      end else if (w_s1_adv) begin
         r_acc <= w_res;
      end
   end

   assign w_op_b = r_s1_inst[3] ? r_acc : r_s1_b;
`else
   logic w_unused_acc_sel;
   assign w_unused_acc_sel = r_s1_inst[3];
   assign w_op_b           = r_s1_b;
`endif

   always_comb begin
      w_res = '0;
      case (r_s1_inst[2:0])
         c_OP_OR:   w_res = r_s1_a | w_op_b;
         c_OP_AND:  w_res = r_s1_a & w_op_b;
         c_OP_XOR:  w_res = r_s1_a ^ w_op_b;
         c_OP_NAND: w_res = ~(r_s1_a & w_op_b);
         c_OP_NOR:  w_res = ~(r_s1_a | w_op_b);
         c_OP_XNOR: w_res = ~(r_s1_a ^ w_op_b);
         c_OP_ANDN: w_res = r_s1_a & ~w_op_b;
         c_OP_PASS: w_res = r_s1_a;
         default:   w_res = '0;
      endcase
   end

   // S1: load wins over drain; a drain without a refill empties the stage.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_inst  <= '0;
         r_s1_valid <= 1'b0;
      end else if (w_in_load) begin
         r_s1_a     <= a;
         r_s1_b     <= b;
         r_s1_inst  <= inst;
         r_s1_valid <= 1'b1;
      end else if (w_s1_adv) begin
         r_s1_valid <= 1'b0;
      end
   end

   // S2: flags are derived from the same result word that is registered, so
   // they always describe the O currently presented.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_s2_o     <= '0;
         r_s2_z     <= 1'b1;
         r_s2_n     <= 1'b0;
         r_s2_p     <= 1'b0;
         r_s2_valid <= 1'b0;
      end else if (w_s1_adv) begin
         r_s2_o     <= w_res;
         r_s2_z     <= ~|w_res;
         r_s2_n     <= w_res[WIDTH-1];
         r_s2_p     <= ^w_res;
         r_s2_valid <= 1'b1;
      end else if (w_out_xfer) begin
         r_s2_valid <= 1'b0;
      end
   end

   assign O         = r_s2_o;
   assign flag_z    = r_s2_z;
   assign flag_n    = r_s2_n;
   assign flag_p    = r_s2_p;
   assign out_valid = r_s2_valid && clk_en;

endmodule
`default_nettype wire

// File: tb/tb_bit_alu_pe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_bit_alu_pe
// Purpose  : Directed self-checking bench for bit_alu_pe (WIDTH=16).
//            Inputs change on the falling edge; outputs are sampled 1 time
//            unit after that, well away from the rising edge.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_bit_alu_pe;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        clk_en;
   logic [3:0]  inst;
   logic [15:0] a;
   logic [15:0] b;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] O;
   logic        flag_z;
   logic        flag_n;
   logic        flag_p;
   logic        out_valid;
   logic        out_ready;

   int checks = 0;
   int errors = 0;

   bit_alu_pe #(.WIDTH(16)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .clk_en    (clk_en),
      .inst      (inst),
      .a         (a),
      .b         (b),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .O         (O),
      .flag_z    (flag_z),
      .flag_n    (flag_n),
      .flag_p    (flag_p),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 CLK = ~CLK;

   task automatic test_reset();
      RESET = 1'b1; clk_en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      inst = 4'd0; a = '0; b = '0;
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || O !== 16'h0000) begin
         errors++; $display("FAIL reset_out: out_valid=%b O=%h required 0/0000", out_valid, O);
      end
      checks++;
      if ({flag_z, flag_n, flag_p} !== 3'b100) begin
         errors++; $display("FAIL reset_flags: znp=%b%b%b required 100", flag_z, flag_n, flag_p);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: %b required 1", in_ready);
      end
   endtask

   task automatic test_opcodes();
      logic [15:0] exp_o [8];
      logic [2:0]  exp_f [8];   // {z,n,p}
      exp_o[0] = 16'h0FFF; exp_f[0] = 3'b000;
      exp_o[1] = 16'h0000; exp_f[1] = 3'b100;
      exp_o[2] = 16'h0FFF; exp_f[2] = 3'b000;
      exp_o[3] = 16'hFFFF; exp_f[3] = 3'b010;
      exp_o[4] = 16'hF000; exp_f[4] = 3'b010;
      exp_o[5] = 16'hF000; exp_f[5] = 3'b010;
      exp_o[6] = 16'h00F0; exp_f[6] = 3'b000;
      exp_o[7] = 16'h00F0; exp_f[7] = 3'b000;
      for (int op = 0; op < 8; op++) begin
         @(negedge CLK);
         inst = {1'b0, 3'(op)}; a = 16'h00F0; b = 16'h0F0F; in_valid = 1'b1;
         @(negedge CLK);
         in_valid = 1'b0;
         #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL op%0d_early: out_valid=%b required 0", op, out_valid);
         end
         @(negedge CLK); #1;
         checks++;
         if (out_valid !== 1'b1 || O !== exp_o[op]) begin
            errors++; $display("FAIL op%0d_result: out_valid=%b O=%h required 1/%h", op, out_valid, O, exp_o[op]);
         end
         checks++;
         if ({flag_z, flag_n, flag_p} !== exp_f[op]) begin
            errors++; $display("FAIL op%0d_flags: znp=%b%b%b required %b", op, flag_z, flag_n, flag_p, exp_f[op]);
         end
      end
      // odd parity case: PASS 0x0001
      @(negedge CLK);
      inst = 4'd7; a = 16'h0001; b = 16'h0000; in_valid = 1'b1;
      @(negedge CLK);
      in_valid = 1'b0;
      @(negedge CLK); #1;
      checks++;
      if (out_valid !== 1'b1 || O !== 16'h0001 || {flag_z, flag_n, flag_p} !== 3'b001) begin
         errors++; $display("FAIL parity: v=%b O=%h znp=%b%b%b required 1/0001/001", out_valid, O, flag_z, flag_n, flag_p);
      end
      @(negedge CLK);
   endtask

   task automatic test_acc();
      logic [15:0] av  [3];
      logic [15:0] exp [3];
      av[0] = 16'h0001; av[1] = 16'h0002; av[2] = 16'h0004;
`ifdef BIT_ALU_PE_ACC_EN
      exp[0] = 16'h0001; exp[1] = 16'h0003; exp[2] = 16'h0007;
`else
      exp[0] = 16'h0001; exp[1] = 16'h0002; exp[2] = 16'h0004;
`endif
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         inst = {(i != 0), 3'd0}; a = av[i]; b = 16'h0000; in_valid = 1'b1;
         @(negedge CLK);
         in_valid = 1'b0;
         @(negedge CLK); #1;
         checks++;
         if (out_valid !== 1'b1 || O !== exp[i]) begin
            errors++; $display("FAIL acc%0d: v=%b O=%h required 1/%h", i, out_valid, O, exp[i]);
         end
      end
      @(negedge CLK);
   endtask

   // mode 0: free stream; 1: out_ready low 5 cycles; 2: clk_en low 3 cycles
   task automatic run_stream(input int mode);
      int          sent = 0, rx = 0, first_rx = -1, last_rx = -1;
      bit          seen_not_ready = 0, held = 0;
      logic [15:0] held_o = '0;
      for (int c = 0; c < 60 && rx < 8; c++) begin
         @(negedge CLK);
         out_ready = !(mode == 1 && c >= 4 && c <= 8);
         clk_en    = !(mode == 2 && c >= 4 && c <= 6);
         in_valid  = (sent < 8);
         inst      = 4'd7;
         a         = 16'h1000 + 16'(sent);
         b         = 16'hFFFF;
         #1;
         if (mode == 0 && sent < 8 && in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL stream_in_ready: cycle %0d in_ready=%b required 1", c, in_ready);
         end
         if (mode == 1 && !out_ready) begin
            if (!in_ready) seen_not_ready = 1;
            if (out_valid) begin
               if (!held) begin held = 1; held_o = O; end
               else begin
                  checks++;
                  if (O !== held_o) begin
                     errors++; $display("FAIL stall_hold: O=%h required %h", O, held_o);
                  end
               end
            end
         end
         if (mode == 2 && !clk_en) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
               errors++; $display("FAIL clk_en_freeze: in_ready=%b out_valid=%b required 0/0", in_ready, out_valid);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (O !== 16'h1000 + 16'(rx)) begin
               errors++; $display("FAIL stream%0d_order: O=%h required %h", mode, O, 16'h1000 + 16'(rx));
            end
            if (first_rx < 0) first_rx = c;
            last_rx = c;
            rx++;
         end
         if (in_valid && in_ready) sent++;
      end
      checks++;
      if (rx != 8) begin
         errors++; $display("FAIL stream%0d_count: received %0d required 8", mode, rx);
      end
      if (mode == 0) begin
         checks++;
         if (last_rx - first_rx != 7) begin
            errors++; $display("FAIL stream_consecutive: span %0d required 7", last_rx - first_rx);
         end
      end
      if (mode == 1) begin
         checks++;
         if (!seen_not_ready) begin
            errors++; $display("FAIL stall_in_ready: in_ready never 0 required 0");
         end
      end
      @(negedge CLK);
      in_valid = 1'b0; out_ready = 1'b1; clk_en = 1'b1;
      repeat (3) begin
         @(negedge CLK); #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL stream%0d_extra: out_valid=%b O=%h required 0", mode, out_valid, O);
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge CLK);
      out_ready = 1'b0; in_valid = 1'b1; inst = 4'd7; a = 16'hABCD; b = 16'h0;
      @(negedge CLK);
      a = 16'h1234;
      @(negedge CLK);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL fill: out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
      end
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0; out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || O !== 16'h0000 || flag_z !== 1'b1) begin
         errors++; $display("FAIL reset_mid: v=%b O=%h z=%b required 0/0000/1", out_valid, O, flag_z);
      end
      repeat (3) begin
         @(negedge CLK); #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_stale: out_valid=%b O=%h required 0", out_valid, O);
         end
      end
   endtask

   initial begin
      test_reset();
      test_opcodes();
      test_acc();
      run_stream(0);
      run_stream(1);
      run_stream(2);
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
